if_fetch_unit: RTL and testbench

Instruction-fetch stage that drives the PC and talks to instruction memory. It buffers returned instructions in a 2-entry queue and presents them, with their PC, to the IF/ID pipeline register. It absorbs ID-side stalls without losing fetched words. On branch/jump redirect it flushes the queue and discards any in-flight memory response.

---
 rtl/if_pkg.sv | 19 +
 rtl/if_fetch_buf.sv | 59 +++++
 rtl/if_fetch_unit.sv | 110 +++++++++++
 tb/tb_if_fetch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam fetch_entry_t NOP_ENTRY = '{instr: NOP_INSTR, pc: 32'h0000_0000};

endpackage

// File: rtl/if_fetch_buf.sv
// Two-entry FIFO of fetched {instr, pc} pairs; the head reads as a NOP entry when empty.
module fetch_buf
    import if_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_instr,
    input  logic [31:0] push_pc,
    input  logic        pop,
    output logic        head_valid,
    output logic [31:0] head_instr,
    output logic [31:0] head_pc,
    output logic [1:0]  count
);

    fetch_entry_t entry_q [2];
    fetch_entry_t push_entry;
    fetch_entry_t head;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;
    logic         wr_idx;

    assign do_pop     = pop && (count_q != 2'd0);
    assign do_push    = push && ((count_q != 2'd2) || do_pop);
    // Slot that the incoming word lands in once this cycle's pop has shifted the queue.
    assign wr_idx     = do_pop ? (count_q == 2'd2) : (count_q == 2'd1);
    assign push_entry = '{instr: push_instr, pc: push_pc};

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            count_q <= 2'd0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // NOTE: entry storage is not reset; count_q alone decides validity, so stale data never leaks.
    always_ff @(posedge clk_i) begin
        if (do_pop) begin
            entry_q[0] <= entry_q[1];
        end
        // NOTE: the later non-blocking write wins, so a push into slot 0 overrides the shift.
        if (do_push) begin
            entry_q[wr_idx] <= push_entry;
        end
    end

    assign head_valid = (count_q != 2'd0);
    assign head       = head_valid ? entry_q[0] : NOP_ENTRY;
    assign head_instr = head.instr;
    assign head_pc    = head.pc;
    assign count      = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives the PC, issues single-outstanding memory requests and
// feeds a two-entry queue towards the IF/ID register; redirects flush and drain stale data.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        id_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  fetch_pc_d;
    logic         outst_q;
    logic         outst_d;
    logic         issue;

    logic [1:0]   count;
    logic         head_valid;
    logic [31:0]  head_instr;
    logic [31:0]  head_pc;
    logic         pop;
    logic         push;
    logic         rsp_accept;
    logic [2:0]   occ_after;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    assign pop        = head_valid && id_ready_i && !redirect_i;
    assign rsp_accept = imem_rvalid_i && outst_q;
    assign push       = rsp_accept && (state_q == RUN) && !redirect_i;
    // Queue occupancy once the in-flight word (if any) lands and this cycle's pop retires.
    assign occ_after  = {1'b0, count} + {2'b00, outst_q} - {2'b00, pop};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        issue      = 1'b0;

        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     issue = !redirect_i && (!outst_q || imem_rvalid_i) && (occ_after < 3'd2);
            DRAIN:   if (rsp_accept) state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            outst_d    = 1'b1;
        end else if (rsp_accept) begin
            outst_d    = 1'b0;
        end

        // A redirect overrides everything; a still-pending stale response forces DRAIN.
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            state_d    = (outst_q && !imem_rvalid_i) ? DRAIN : RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            outst_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
        end
    end

    assign imem_req_o  = issue;
    assign imem_addr_o = issue ? fetch_pc_q : 32'h0000_0000;

    // Only one request is ever in flight and fetch_pc has advanced past it, so its PC is fetch_pc - 4.
    fetch_buf u_fetch_buf (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .flush      (redirect_i),
        .push       (push),
        .push_instr (imem_rdata_i),
        .push_pc    (fetch_pc_q - 32'd4),
        .pop        (pop),
        .head_valid (head_valid),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .count      (count)
    );

    assign valid_o = head_valid;
    assign instr_o = head_instr;
    assign pc_o    = head_pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed phases push expected {instr, pc} entries,
// a monitor pops and compares every instruction the ID side consumes.
module tb_if_fetch_unit;
    import if_pkg::*;

    localparam logic [31:0] KEY     = 32'hA5A5_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        id_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i  = 32'h0;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata  = 32'h0;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;

    int           n_cmp = 0;
    int           n_bad = 0;
    fetch_entry_t exp_q [$];
    fetch_entry_t mon_e;

    int          mem_lat     = 1;
    logic        mem_keep    = 1'b0;
    logic        mem_pend    = 1'b0;
    int          mem_wait    = 0;
    logic [31:0] mem_addr    = 32'h0;
    logic        exp_outst   = 1'b0;
    int          illegal_rsp = 0;
    logic        w_pend      = 1'b0;
    logic [31:0] w_req_addr  = 32'h0;

    always #5 clk_i = ~clk_i;

    if_fetch_unit dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .id_ready_i    (id_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    if_fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .id_ready_i    (id_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (w_req),
        .imem_addr_o   (w_addr),
        .imem_rvalid_i (w_rvalid),
        .imem_rdata_i  (w_rdata),
        .valid_o       (w_valid),
        .instr_o       (w_instr),
        .pc_o          (w_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst_n, input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk_i);
        reset_ni      = rst_n;
        id_ready_i    = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        #2;
    endtask

    task automatic expect_word(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = pc ^ KEY;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int lat);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        exp_q.delete();
        mem_lat = lat;
    endtask

    // Memory with programmable latency for the main DUT; tracks what should be outstanding.
    always begin
        @(negedge clk_i);
        if (mem_pend && mem_wait <= 1) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_addr ^ KEY;
            mem_pend      = 1'b0;
            if (!exp_outst) illegal_rsp++;
            exp_outst = 1'b0;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'hDEAD_BEEF;
            if (mem_pend) mem_wait--;
        end
        #1;
        if (!reset_ni) begin
            exp_outst = 1'b0;
            if (!mem_keep) mem_pend = 1'b0;
        end else if (imem_req_o) begin
            mem_pend  = 1'b1;
            mem_wait  = mem_lat;
            mem_addr  = imem_addr_o;
            exp_outst = 1'b1;
        end
    end

    // Fixed 1-cycle memory for the wrap-around instance.
    always begin
        @(negedge clk_i);
        w_rvalid = w_pend;
        w_rdata  = w_req_addr ^ KEY;
        w_pend   = 1'b0;
        #1;
        if (reset_ni && w_req) begin
            w_pend     = 1'b1;
            w_req_addr = w_addr;
        end
    end

    // Monitor: every consumed head instruction must match the next scoreboard entry.
    always begin
        @(negedge clk_i);
        #3;
        if (reset_ni && valid_o && id_ready_i && !redirect_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_instr: got pc %h instr %h, required no instruction", pc_o, instr_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_pc", pc_o, mon_e.pc);
                check("mon_instr", instr_o, mon_e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_ni      = 1'b0;
        id_ready_i    = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;

        // Reset values, throughput and wrap-around.
        do_reset(1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_instr", instr_o, NOP_INSTR);
        check("rst_pc", pc_o, 32'h0);
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_addr", imem_addr_o, 32'h0);
        for (int i = 0; i < 20; i++) expect_word(32'(4 * i));
        for (int c = 0; c <= 12; c++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (c == 0) check("a_req_c0", 32'(imem_req_o), 32'd0);
            if (c == 1 || c == 2) begin
                check($sformatf("a_req_c%0d", c), 32'(imem_req_o), 32'd1);
                check($sformatf("a_addr_c%0d", c), imem_addr_o, 32'(4 * (c - 1)));
            end
            if (c <= 2) check($sformatf("a_valid_c%0d", c), 32'(valid_o), 32'd0);
            if (c >= 3) check($sformatf("a_nobubble_c%0d", c), 32'(valid_o), 32'd1);
            if (c >= 1 && c <= 3) check($sformatf("wrap_addr_c%0d", c), w_addr, WRAP_PC + 32'(4 * (c - 1)));
            if (c >= 3 && c <= 5) check($sformatf("wrap_pc_c%0d", c), w_pc, WRAP_PC + 32'(4 * (c - 3)));
            if (c == 5) check("wrap_instr_c5", w_instr, KEY);
        end

        // Stall for 5 cycles mid-stream, then resume.
        for (int c = 13; c <= 17; c++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            check($sformatf("b_req_stall_c%0d", c), 32'(imem_req_o), 32'd0);
            check($sformatf("b_valid_stall_c%0d", c), 32'(valid_o), 32'd1);
            check($sformatf("b_pc_hold_c%0d", c), pc_o, 32'd40);
            check($sformatf("b_instr_hold_c%0d", c), instr_o, 32'd40 ^ KEY);
        end
        for (int c = 18; c <= 27; c++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (c == 18) begin
                check("b_req_resume", 32'(imem_req_o), 32'd1);
                check("b_addr_resume", imem_addr_o, 32'd48);
            end
            check($sformatf("b_valid_c%0d", c), 32'(valid_o), 32'd1);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("ab_all_consumed", 32'(exp_q.size()), 32'd0);

        // 3-cycle memory, redirect while a request is outstanding.
        do_reset(3);
        for (int c = 0; c <= 12; c++) begin
            step(1'b1, 1'b1, c == 2, 32'h0000_0102);
            if (c == 2) begin
                expect_word(32'h100);
                expect_word(32'h104);
            end
            if (c == 1) check("c_addr_c1", imem_addr_o, 32'h0);
            if (c >= 2 && c <= 4) check($sformatf("c_req_c%0d", c), 32'(imem_req_o), 32'd0);
            if (c == 3) check("c_valid_after_redirect", 32'(valid_o), 32'd0);
            if (c == 5 || c == 8) begin
                check($sformatf("c_req_c%0d", c), 32'(imem_req_o), 32'd1);
                check($sformatf("c_addr_c%0d", c), imem_addr_o, (c == 5) ? 32'h100 : 32'h104);
            end
            if (c == 6 || c == 7) check($sformatf("c_req_c%0d", c), 32'(imem_req_o), 32'd0);
            if (c == 9) begin
                check("c_valid_c9", 32'(valid_o), 32'd1);
                check("c_pc_c9", pc_o, 32'h100);
            end
            if (c == 10 || c == 11) check($sformatf("c_valid_c%0d", c), 32'(valid_o), 32'd0);
            if (c == 12) check("c_pc_c12", pc_o, 32'h104);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("c_all_consumed", 32'(exp_q.size()), 32'd0);

        // Redirect alongside rvalid, then again during DRAIN.
        do_reset(3);
        for (int c = 0; c <= 13; c++) begin
            logic        redir;
            logic [31:0] tgt;
            redir = (c == 4) || (c == 6) || (c == 7);
            tgt   = (c == 4) ? 32'h200 : (c == 6) ? 32'h300 : 32'h404;
            step(1'b1, 1'b1, redir, tgt);
            if (c == 7) expect_word(32'h404);
            if (c == 4 || c == 6 || c == 7 || c == 8) check($sformatf("d_req_c%0d", c), 32'(imem_req_o), 32'd0);
            if (c == 5) check("d_addr_c5", imem_addr_o, 32'h200);
            if (c == 9) begin
                check("d_req_c9", 32'(imem_req_o), 32'd1);
                check("d_addr_c9", imem_addr_o, 32'h404);
            end
            if (c >= 5 && c <= 12) check($sformatf("d_valid_c%0d", c), 32'(valid_o), 32'd0);
            if (c == 13) check("d_pc_c13", pc_o, 32'h404);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("d_all_consumed", 32'(exp_q.size()), 32'd0);

        // Redirect with a full queue: head dropped, target fetched next cycle.
        do_reset(1);
        for (int c = 0; c <= 8; c++) begin
            step(1'b1, c >= 4, c == 4, 32'h50);
            if (c == 4) begin
                expect_word(32'h50);
                expect_word(32'h54);
                check("e_req_redirect", 32'(imem_req_o), 32'd0);
            end
            if (c == 3) check("e_pc_full_c3", pc_o, 32'h0);
            if (c == 5) begin
                check("e_valid_c5", 32'(valid_o), 32'd0);
                check("e_addr_c5", imem_addr_o, 32'h50);
            end
            if (c == 7) check("e_pc_c7", pc_o, 32'h50);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("e_all_consumed", 32'(exp_q.size()), 32'd0);

        // Reset with a queued word and an outstanding request; late response must be ignored.
        do_reset(3);
        for (int c = 0; c <= 4; c++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            if (c == 4) check("f_addr_c4", imem_addr_o, 32'h4);
        end
        mem_keep = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("f_valid_before_reset", 32'(valid_o), 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("f_rst_valid", 32'(valid_o), 32'd0);
        check("f_rst_instr", instr_o, NOP_INSTR);
        check("f_rst_pc", pc_o, 32'h0);
        check("f_rst_req", 32'(imem_req_o), 32'd0);
        check("f_rst_addr", imem_addr_o, 32'h0);
        exp_q.delete();
        expect_word(32'h0);
        for (int p = 0; p <= 5; p++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (p == 0) begin
                mem_keep = 1'b0;
                check("f_late_rsp_flagged", 32'(illegal_rsp), 32'd1);
                check("f_req_p0", 32'(imem_req_o), 32'd0);
            end
            if (p == 1) begin
                check("f_req_p1", 32'(imem_req_o), 32'd1);
                check("f_addr_p1", imem_addr_o, 32'h0);
            end
            if (p <= 4) check($sformatf("f_valid_p%0d", p), 32'(valid_o), 32'd0);
            if (p == 5) check("f_valid_p5", 32'(valid_o), 32'd1);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("f_all_consumed", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
